fifo_drain_fsm: RTL and testbench
=================================

# fifo_drain_fsm

Read-side controller for the HDMI-out pixel FIFO: drains 32-bit words toward the HDMI core at the core's request and counts words and lines. It produces the `half_full`, `hsync` and `vsync` event pulses that the FIFO-fill address FSM consumes to advance its DDR read address. It sits in `hdmi_out` user_logic between the pixel FIFO read port and the HDMI core pixel input.

## Interface
Parameters:
- `HALF_WORDS`, default 64: words per half-FIFO; a `half_full` pulse is emitted every `HALF_WORDS` reads within a line. Must be a power of 2.

Ports (one clock; reset is synchronous and active-high):
- `Bus2IP_Clk`  in  1  sole clock; all state updates on rising edge.
- `Bus2IP_Reset`  in  1  synchronous, active-high reset.
- `start_drain`  in  1  level; begin a frame when in IDLE.
- `pixel_ready`  in  1  HDMI core requests one word this cycle.
- `fifo_empty`  in  1  pixel FIFO empty flag.
- `fifo_dout`  in  32  FIFO read data; valid the cycle after `fifo_rd_en`.
- `NUM_WORDS_PER_LINE`  in  32  words per line, from slv_reg.
- `NUM_LINES_PER_FRAME`  in  32  lines per frame, from slv_reg.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `pixel_data`  out  32  word to the HDMI core; equals `fifo_dout` whenever `pixel_valid`=1.
- `pixel_valid`  out  1  `pixel_data` valid.
- `half_full`  out  1  one-cycle pulse: a half-FIFO of words has been consumed.
- `hsync`  out  1  one-cycle pulse: end of line.
- `vsync`  out  1  one-cycle pulse: end of frame.
- `underflow`  out  1  sticky: a request was made while the FIFO was empty.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation
States: IDLE, PRIME, ACTIVE, LINE_END, FRAME_END (3-bit encoding).

- **IDLE**
  - If `start_drain`=1 and both config values are nonzero: latch `NUM_WORDS_PER_LINE` and `NUM_LINES_PER_FRAME` into internal registers, clear `word_cnt`, `line_cnt` and `underflow`, then go to PRIME.
  - If either config value is zero, `start_drain` is ignored and the block stays in IDLE.
- **PRIME**: wait for `fifo_empty`=0, then go to ACTIVE. No reads and no underflow checking in this state.
- **ACTIVE**
  - `fifo_rd_en` = ACTIVE & `pixel_ready` & !`fifo_empty` (combinational).
  - Each read increments `word_cnt` (32-bit).
  - The read with `word_cnt` = latched_words−1 resets `word_cnt` to 0 and moves the FSM to LINE_END; or to FRAME_END if `line_cnt` = latched_lines−1.
  - `pixel_ready`=1 with `fifo_empty`=1 sets `underflow`; counters hold and there is no pulse.
- **LINE_END**: `hsync`=1 for one cycle; `line_cnt` increments; no read this cycle; go to ACTIVE.
- **FRAME_END**: `vsync`=1 for one cycle; no read; go to IDLE. If `start_drain` is still high, the next frame starts via IDLE→PRIME.
- **half_full**: pulses in the cycle after a read for which (`word_cnt`+1) mod `HALF_WORDS` = 0, unless that read was the last word of a line.
- **Event priority**: at most one pulse per cycle; vsync > hsync > half_full, matching the fill FSM's decode order.
- **Configuration**: the latched config is used for the whole frame. Changes to the slv_reg inputs mid-frame have no effect until the next start.
- **start_drain mid-frame**: deassertion is ignored and the frame completes.
- **Illegal state encodings**: recover to IDLE on the next edge.

## Timing
- Reset: on the edge with `Bus2IP_Reset`=1, the state goes to IDLE and all counters are cleared. All outputs are then 0: `fifo_rd_en`, `pixel_valid`, `pixel_data` (0x0), `half_full`, `hsync`, `vsync`, `underflow`, `busy`. Reset mid-frame aborts immediately, with no pulse.
- Read latency: `fifo_rd_en` high in cycle N gives `pixel_valid`=1 in cycle N+1, with `pixel_data`=`fifo_dout`.
  - `pixel_valid` is registered.
  - `pixel_data` is forced to 0 when `pixel_valid`=0.
- `half_full` is registered and coincides with the `pixel_valid` cycle of the triggering word.
- `hsync` and `vsync` are asserted in the LINE_END or FRAME_END cycle. That cycle is the same one in which the last word's `pixel_valid` is high.
- Throughput: one word per cycle inside a line, plus a one-cycle gap per line. Frame overhead is one FRAME_END cycle plus one IDLE cycle plus at least one PRIME cycle.
- `start_drain` → first possible `fifo_rd_en`: 2 cycles if the FIFO is non-empty (IDLE→PRIME→ACTIVE).

## Test plan
1. **Reset values**: drive reset for 3 cycles mid-ACTIVE → all outputs 0 on the next cycle, `busy`=0; with `start_drain` low, the block stays in IDLE.
2. **Small frame**: words=4, lines=2, `pixel_ready`=1, FIFO never empty.
   - Expect 8 reads; `hsync` in cycle 5; `vsync` 5 cycles later.
   - `half_full` never fires.
   - `pixel_data` sequence matches the FIFO contents.
3. **Half events**: words=160, lines=1.
   - `half_full` pulses after words 64 and 128.
   - `vsync` after word 160, with no `hsync`.
   - words=128 → exactly one `half_full` (word 64), and `hsync`/`vsync` take priority at word 128.
4. **Underflow**: `fifo_empty`=1 for 3 cycles while ACTIVE with `pixel_ready`=1.
   - `underflow`=1 and stays high.
   - `word_cnt` holds and there are no reads.
   - Resumes when the FIFO refills; the next `start_drain` clears the flag.
5. **Config latch/zero**: words=0 with `start_drain`=1 → stays IDLE. Changing words from 8 to 16 mid-frame → the current frame still uses 8.
6. **Back-to-back frames**: `start_drain` held high, words=2, lines=1 → `vsync`, then IDLE, PRIME, ACTIVE; the second frame's first read occurs 3 cycles after `vsync`.

Source files
------------

// File: rtl/fifo_drain_if.sv
// Handshake and data bundle between the pixel FIFO read port, the slv_reg
// configuration and the HDMI core pixel input.
interface fifo_drain_if;
    logic        start_drain;
    logic        pixel_ready;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic [31:0] NUM_WORDS_PER_LINE;
    logic [31:0] NUM_LINES_PER_FRAME;

    logic        fifo_rd_en;
    logic [31:0] pixel_data;
    logic        pixel_valid;
    logic        half_full;
    logic        hsync;
    logic        vsync;
    logic        underflow;
    logic        busy;

    // master drives the requests, FIFO data and configuration
    modport master (
        output start_drain, pixel_ready, fifo_empty, fifo_dout,
               NUM_WORDS_PER_LINE, NUM_LINES_PER_FRAME,
        input  fifo_rd_en, pixel_data, pixel_valid, half_full,
               hsync, vsync, underflow, busy
    );

    modport slave (
        input  start_drain, pixel_ready, fifo_empty, fifo_dout,
               NUM_WORDS_PER_LINE, NUM_LINES_PER_FRAME,
        output fifo_rd_en, pixel_data, pixel_valid, half_full,
               hsync, vsync, underflow, busy
    );
endinterface

// File: rtl/fifo_drain_fsm.sv
// Read-side drain controller for the HDMI-out pixel FIFO: paces word reads to
// the HDMI core and emits half_full/hsync/vsync events for the fill FSM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start_drain with nonzero config
// PRIME     | frame started, waiting for the FIFO to become non-empty
// ACTIVE    | reading one word per pixel_ready, counting words of the line
// LINE_END  | hsync cycle, advance line counter, no read
// FRAME_END | vsync cycle, no read, return to IDLE
module fifo_drain_fsm #(
    parameter int unsigned HALF_WORDS = 64
) (
    input  logic         Bus2IP_Clk,
    input  logic         Bus2IP_Reset,
    fifo_drain_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRIME     = 3'd1,
        S_ACTIVE    = 3'd2,
        S_LINE_END  = 3'd3,
        S_FRAME_END = 3'd4
    } state_t;

    localparam logic [31:0] HALF_MASK = 32'(HALF_WORDS - 1);

    state_t      state_q, state_d;
    logic [31:0] words_q, words_d;
    logic [31:0] lines_q, lines_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] line_cnt_q, line_cnt_d;
    logic        underflow_q, underflow_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        half_full_q, half_full_d;

    logic        rd_en;
    logic        cfg_ok;
    logic        last_word;
    logic        last_line;
    logic [31:0] word_cnt_inc;

    always_comb begin
        state_d       = state_q;
        words_d       = words_q;
        lines_d       = lines_q;
        word_cnt_d    = word_cnt_q;
        line_cnt_d    = line_cnt_q;
        underflow_d   = underflow_q;
        pixel_valid_d = 1'b0;
        half_full_d   = 1'b0;
        rd_en         = 1'b0;

        cfg_ok       = (bus.NUM_WORDS_PER_LINE != 32'd0) && (bus.NUM_LINES_PER_FRAME != 32'd0);
        word_cnt_inc = word_cnt_q + 32'd1;
        last_word    = (word_cnt_q == words_q - 32'd1);
        last_line    = (line_cnt_q == lines_q - 32'd1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_drain && cfg_ok) begin
                    words_d     = bus.NUM_WORDS_PER_LINE;
                    lines_d     = bus.NUM_LINES_PER_FRAME;
                    word_cnt_d  = 32'd0;
                    line_cnt_d  = 32'd0;
                    underflow_d = 1'b0;
                    state_d     = S_PRIME;
                end
            end
            S_PRIME: begin
                if (!bus.fifo_empty) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (bus.pixel_ready && bus.fifo_empty) begin
                    underflow_d = 1'b1;
                end
                if (bus.pixel_ready && !bus.fifo_empty) begin
                    rd_en         = 1'b1;
                    pixel_valid_d = 1'b1;
                    // last word of a line never raises half_full; hsync/vsync cover it
                    if (last_word) begin
                        word_cnt_d = 32'd0;
                        state_d    = last_line ? S_FRAME_END : S_LINE_END;
                    end else begin
                        word_cnt_d  = word_cnt_inc;
                        half_full_d = ((word_cnt_inc & HALF_MASK) == 32'd0);
                    end
                end
            end
            S_LINE_END: begin
                line_cnt_d = line_cnt_q + 32'd1;
                state_d    = S_ACTIVE;
            end
            S_FRAME_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q       <= S_IDLE;
            words_q       <= 32'd0;
            lines_q       <= 32'd0;
            word_cnt_q    <= 32'd0;
            line_cnt_q    <= 32'd0;
            underflow_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            half_full_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            words_q       <= words_d;
            lines_q       <= lines_d;
            word_cnt_q    <= word_cnt_d;
            line_cnt_q    <= line_cnt_d;
            underflow_q   <= underflow_d;
            pixel_valid_q <= pixel_valid_d;
            half_full_q   <= half_full_d;
        end
    end

    assign bus.fifo_rd_en  = rd_en;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pixel_data  = pixel_valid_q ? bus.fifo_dout : 32'd0;
    assign bus.vsync       = (state_q == S_FRAME_END);
    assign bus.hsync       = (state_q == S_LINE_END);
    assign bus.half_full   = half_full_q & ~bus.hsync & ~bus.vsync;
    assign bus.underflow   = underflow_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_drain_fsm.sv
// Self-checking bench for fifo_drain_fsm: directed frames plus randomized
// pixel_ready pacing, checked against frame-level word/event expectations.
module tb_fifo_drain_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_drain_if bus();

    fifo_drain_fsm #(.HALF_WORDS(64)) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .bus          (bus)
    );

    localparam int HALF = 64;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [4096];
    int          rd_ptr = 0;

    // FIFO model: registered read data, never runs dry unless fifo_empty is forced
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_dout <= mem[rd_ptr % 4096];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd_en"},     bus.fifo_rd_en,  0);
        check({tag, "_valid"},     bus.pixel_valid, 0);
        check({tag, "_data"},      bus.pixel_data,  0);
        check({tag, "_half_full"}, bus.half_full,   0);
        check({tag, "_hsync"},     bus.hsync,       0);
        check({tag, "_vsync"},     bus.vsync,       0);
        check({tag, "_underflow"}, bus.underflow,   0);
        check({tag, "_busy"},      bus.busy,        0);
    endtask

    // Runs one frame of w words x l lines. lead=1 means start is already held
    // high from the previous frame, which is sitting in its vsync cycle.
    task automatic run_frame(input int w, input int l, input bit rnd, input int lead,
                             input bit hold, input int empty_at, input int new_words);
        int base, got, cyc, vs_at, first_rd, multi, budget;
        int halfs[$], hss[$], exp_h[$], exp_hs[$];
        bit done;
        bus.NUM_WORDS_PER_LINE  = w;
        bus.NUM_LINES_PER_FRAME = l;
        bus.start_drain = 1'b1;
        bus.pixel_ready = 1'b1;
        base = rd_ptr;
        got = 0; cyc = 0; vs_at = -1; first_rd = -1; multi = 0; done = 0;
        budget = 8 * (w + 2) * l + 40;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (first_rd < 0 && bus.fifo_rd_en) first_rd = cyc;
            if (bus.pixel_valid) begin
                check("pixel_data", bus.pixel_data, mem[(base + got) % 4096]);
                got++;
            end
            if (int'(bus.half_full) + int'(bus.hsync) + int'(bus.vsync) > 1) multi++;
            if (bus.half_full) halfs.push_back(got);
            if (bus.hsync) hss.push_back(got);
            if (bus.vsync) begin
                vs_at = cyc;
                done  = 1;
            end
            if (cyc == 1) check("busy_cycle1", bus.busy, (lead == 0));
            if (cyc == lead + 1 && !hold) bus.start_drain = 1'b0;
            if (cyc == 3 && new_words != 0) begin
                bus.NUM_WORDS_PER_LINE  = new_words;
                bus.NUM_LINES_PER_FRAME = l + 1;
            end
            if (empty_at > 0 && cyc > empty_at && cyc <= empty_at + 3)
                check("no_read_when_empty", bus.fifo_rd_en, 0);
            if (empty_at > 0) bus.fifo_empty = (cyc >= empty_at && cyc < empty_at + 3);
            if (rnd) bus.pixel_ready = ($urandom_range(3) != 0);
        end
        bus.fifo_empty = 1'b0;
        check("vsync_seen", done, 1);
        check("word_count", got, w * l);
        if (!rnd) check("vsync_cycle", vs_at, lead + 1 + l * (w + 1) + (empty_at > 0 ? 3 : 0));
        if (!rnd && empty_at == 0) check("first_rd_cycle", first_rd, lead + 2);
        for (int li = 0; li < l; li++) begin
            for (int k = HALF; k < w; k += HALF) exp_h.push_back(li * w + k);
            if (li < l - 1) exp_hs.push_back((li + 1) * w);
        end
        check("half_count", halfs.size(), exp_h.size());
        for (int i = 0; i < halfs.size() && i < exp_h.size(); i++)
            check("half_pos", halfs[i], exp_h[i]);
        check("hsync_count", hss.size(), exp_hs.size());
        for (int i = 0; i < hss.size() && i < exp_hs.size(); i++)
            check("hsync_pos", hss[i], exp_hs[i]);
        check("multi_pulse", multi, 0);
        check("underflow", bus.underflow, (empty_at > 0));
        if (!hold) begin
            @(negedge clk);
            check("idle_after_frame", bus.busy, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        rst = 1'b1;
        bus.start_drain = 1'b0;
        bus.pixel_ready = 1'b0;
        bus.fifo_empty  = 1'b0;
        bus.NUM_WORDS_PER_LINE  = 32'd0;
        bus.NUM_LINES_PER_FRAME = 32'd0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle_no_start");

        // small frame, then half-FIFO event frames
        run_frame(4, 2, 0, 0, 0, 0, 0);
        run_frame(160, 1, 0, 0, 0, 0, 0);
        run_frame(128, 1, 0, 0, 0, 0, 0);
        run_frame(128, 2, 0, 0, 0, 0, 0);

        // underflow, then a fresh start clears it
        run_frame(8, 1, 0, 0, 0, 4, 0);
        run_frame(4, 1, 0, 0, 0, 0, 0);

        // zero config is ignored
        bus.NUM_WORDS_PER_LINE  = 0;
        bus.NUM_LINES_PER_FRAME = 3;
        bus.start_drain = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("zero_words_busy", bus.busy, 0);
            check("zero_words_rd", bus.fifo_rd_en, 0);
        end
        bus.NUM_WORDS_PER_LINE  = 5;
        bus.NUM_LINES_PER_FRAME = 0;
        repeat (3) begin
            @(negedge clk);
            check("zero_lines_busy", bus.busy, 0);
        end
        bus.start_drain = 1'b0;
        @(negedge clk);

        // mid-frame config change must not affect the running frame
        run_frame(8, 2, 0, 0, 0, 0, 16);

        // back-to-back frames with start held
        run_frame(2, 1, 0, 0, 1, 0, 0);
        run_frame(2, 1, 0, 1, 0, 0, 0);

        // randomized pacing and sizes
        repeat (6) begin
            run_frame($urandom_range(150, 1), $urandom_range(3, 1), 1, 0, 0, 0, 0);
        end

        // reset in the middle of a frame
        bus.NUM_WORDS_PER_LINE  = 20;
        bus.NUM_LINES_PER_FRAME = 2;
        bus.start_drain = 1'b1;
        bus.pixel_ready = 1'b1;
        repeat (6) @(negedge clk);
        bus.start_drain = 1'b0;
        check("busy_before_reset", bus.busy, 1);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_quiet("reset_mid_frame");
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stay_idle_busy", bus.busy, 0);
            check("stay_idle_valid", bus.pixel_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
